async_sram_target: RTL and testbench

Synthesisable single-clock responder for the asynchronous SRAM bus: it sits on the far side of the SRAM pads and behaves as a 16-bit external asynchronous SRAM with byte lanes. It is used for FPGA prototyping and pad-loopback test builds, where no physical SRAM is fitted. It oversamples the strobes, commits writes on WE_n deassertion and drives read data back onto DQ. Storage is a small register-file array; upper address bits alias.

---
 rtl/async_sram_target_pkg.sv | 11 +
 rtl/async_sram_target_mem.sv | 25 ++
 rtl/async_sram_target.sv | 153 +++++++++++++++
 tb/tb_async_sram_target.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/async_sram_target_pkg.sv
// Shared definitions for the async SRAM target: FSM encoding and data lane geometry.
package async_sram_target_pkg;
  localparam int SRAM_DQ_W = 16;
  localparam int N_LANES   = SRAM_DQ_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;
endpackage

// File: rtl/async_sram_target_mem.sv
// Byte-lane writable register array: one write port, one combinational read port.
module async_sram_target_mem
  import async_sram_target_pkg::*;
#(
  parameter int N_A = 6
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [N_LANES-1:0]   be_i,
  input  logic [N_A-1:0]       waddr_i,
  input  logic [SRAM_DQ_W-1:0] wdata_i,
  input  logic [N_A-1:0]       raddr_i,
  output logic [SRAM_DQ_W-1:0] rdata_o
);
  // One array per lane keeps each lane's storage driven from a single process.
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    logic [7:0] lane_q [2**N_A];

    always_ff @(posedge clk) begin
      if (we_i && be_i[l]) lane_q[waddr_i] <= wdata_i[8*l +: 8];
    end

    assign rdata_o[8*l +: 8] = lane_q[raddr_i];
  end
endmodule

// File: rtl/async_sram_target.sv
// Responder that behaves as a 16-bit byte-lane async SRAM on the pad side.
// Optional protocol checker: define ASYNC_SRAM_TARGET_ERR_CHECK_EN.
module async_sram_target
  import async_sram_target_pkg::*;
#(
  parameter int N_SRAM_A  = 18,
  parameter int N_MEM_A   = 6,
  parameter int N_SRAM_DQ = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRAM_A-1:0]  sram_a,
  input  logic [N_SRAM_DQ-1:0] sram_dq_in,
  output logic [N_SRAM_DQ-1:0] sram_dq_out,
  output logic [N_SRAM_DQ-1:0] sram_dq_oe,
  input  logic                 sram_cs_n,
  input  logic                 sram_oe_n,
  input  logic                 sram_we_n,
  input  logic                 sram_ub_n,
  input  logic                 sram_lb_n,
  output logic                 err
);
  logic [N_MEM_A-1:0]   a_s_q;
  logic [N_SRAM_DQ-1:0] dq_s_q;
  logic                 cs_n_s_q, oe_n_s_q, we_n_s_q, ub_n_s_q, lb_n_s_q;

  state_e               state_q, state_d;
  logic [N_MEM_A-1:0]   pend_a_q, pend_a_d;
  logic [N_SRAM_DQ-1:0] pend_dq_q, pend_dq_d;
  logic [N_LANES-1:0]   pend_be_q, pend_be_d;
  logic [N_SRAM_DQ-1:0] dq_out_q, dq_out_d;
  logic [N_SRAM_DQ-1:0] dq_oe_q, dq_oe_d;

  logic                 commit;
  logic [N_LANES-1:0]   be_s;
  logic [N_SRAM_DQ-1:0] mem_rdata, rd_word, rd_masked;

  // Upper address bits alias onto the implemented array.
  if (N_MEM_A < N_SRAM_A) begin : g_alias
    logic unused_a_hi;
    assign unused_a_hi = ^sram_a[N_SRAM_A-1:N_MEM_A];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s_q    <= '0;
      dq_s_q   <= '0;
      cs_n_s_q <= 1'b1;
      oe_n_s_q <= 1'b1;
      we_n_s_q <= 1'b1;
      ub_n_s_q <= 1'b1;
      lb_n_s_q <= 1'b1;
    end else begin
      a_s_q    <= sram_a[N_MEM_A-1:0];
      dq_s_q   <= sram_dq_in;
      cs_n_s_q <= sram_cs_n;
      oe_n_s_q <= sram_oe_n;
      we_n_s_q <= sram_we_n;
      ub_n_s_q <= sram_ub_n;
      lb_n_s_q <= sram_lb_n;
    end
  end

  assign be_s = {~ub_n_s_q, ~lb_n_s_q};

  async_sram_target_mem #(.N_A(N_MEM_A)) u_mem (
    .clk     (clk),
    .we_i    (commit && (|pend_be_q)),
    .be_i    (pend_be_q),
    .waddr_i (pend_a_q),
    .wdata_i (pend_dq_q),
    .raddr_i (a_s_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_a_q  <= '0;
      pend_dq_q <= '0;
      pend_be_q <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_a_q  <= pend_a_d;
      pend_dq_q <= pend_dq_d;
      pend_be_q <= pend_be_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  always_comb begin
    state_d   = ST_IDLE;
    pend_a_d  = pend_a_q;
    pend_dq_d = pend_dq_q;
    pend_be_d = pend_be_q;
    dq_out_d  = dq_out_q;
    dq_oe_d   = '0;
    if (!cs_n_s_q) begin
      if (!we_n_s_q)      state_d = ST_WRITE;
      else if (!oe_n_s_q) state_d = ST_READ;
    end
    commit = (state_q == ST_WRITE) && (state_d != ST_WRITE);

    if (state_d == ST_WRITE) begin
      pend_a_d  = a_s_q;
      pend_dq_d = dq_s_q;
      pend_be_d = be_s;
    end

    // A commit landing on the address being read forwards the new lanes.
    rd_word = mem_rdata;
    for (int l = 0; l < N_LANES; l++) begin
      if (commit && pend_be_q[l] && (pend_a_q == a_s_q))
        rd_word[8*l +: 8] = pend_dq_q[8*l +: 8];
      rd_masked[8*l +: 8] = be_s[l] ? rd_word[8*l +: 8] : 8'h00;
    end

    if (state_d == ST_READ) begin
      dq_out_d = rd_masked;
      dq_oe_d  = '1;
    end
  end

  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;

`ifdef ASYNC_SRAM_TARGET_ERR_CHECK_EN
  logic err_q, err_d, we_n_p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      we_n_p_q <= 1'b1;
    end else begin
      err_q    <= err_d;
      we_n_p_q <= we_n_s_q;
    end
  end

  always_comb begin
    err_d = err_q
          | (~cs_n_s_q & ~we_n_s_q & ~oe_n_s_q)
          | (we_n_p_q & ~we_n_s_q & cs_n_s_q);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_async_sram_target.sv
// Scoreboarded bench for async_sram_target: writes, lane masking, aliasing, reset, err, bypass.
module tb_async_sram_target;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] a = '0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out, dq_oe;
  logic        cs_n = 1'b1, oe_n = 1'b1, we_n = 1'b1, ub_n = 1'b1, lb_n = 1'b1;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [15:0] model [64];
  logic [15:0] exp_q [$];

`ifdef ASYNC_SRAM_TARGET_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  async_sram_target #(.N_SRAM_A(18), .N_MEM_A(6), .N_SRAM_DQ(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .sram_a      (a),
    .sram_dq_in  (dq_in),
    .sram_dq_out (dq_out),
    .sram_dq_oe  (dq_oe),
    .sram_cs_n   (cs_n),
    .sram_oe_n   (oe_n),
    .sram_we_n   (we_n),
    .sram_ub_n   (ub_n),
    .sram_lb_n   (lb_n),
    .err         (err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [17:0] ad, input logic [15:0] d, input logic ubn, input logic lbn);
    if (!lbn) model[ad[5:0]][7:0]  = d[7:0];
    if (!ubn) model[ad[5:0]][15:8] = d[15:8];
  endtask

  task automatic bus_write(input logic [17:0] ad, input logic [15:0] d, input logic ubn, input logic lbn);
    a = ad; dq_in = d; ub_n = ubn; lb_n = lbn; cs_n = 1'b0;
    tick(1);
    we_n = 1'b0;
    tick(4);
    we_n = 1'b1;
    tick(1);
    cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    tick(2);
    model_write(ad, d, ubn, lbn);
  endtask

  task automatic bus_read(input logic [17:0] ad, input logic ubn, input logic lbn, input string nm);
    logic [15:0] e, got;
    int cyc;
    e = {ubn ? 8'h00 : model[ad[5:0]][15:8], lbn ? 8'h00 : model[ad[5:0]][7:0]};
    exp_q.push_back(e);
    a = ad; ub_n = ubn; lb_n = lbn; cs_n = 1'b0; oe_n = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (dq_oe !== 16'hFFFF && cyc < 8);
    checks++;
    if (cyc !== 2) begin
      failures++;
      $display("FAIL %s_latency: oe valid after %0d edges, required 2", nm, cyc);
    end
    got = dq_out;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s_data: dq_out=%h required %h", nm, got, e);
    end
    oe_n = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (dq_oe !== 16'h0000 && cyc < 8);
    checks++;
    if (cyc !== 2) begin
      failures++;
      $display("FAIL %s_oe_off: oe low after %0d edges, required 2", nm, cyc);
    end
    checks++;
    if (dq_out !== e) begin
      failures++;
      $display("FAIL %s_hold: dq_out=%h required %h", nm, dq_out, e);
    end
    cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if (dq_out !== 16'h0 || dq_oe !== 16'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out=%h oe=%h err=%b required 0/0/0", dq_out, dq_oe, err);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write_read;
    bus_write(18'h00005, 16'hA5C3, 1'b0, 1'b0);
    bus_read(18'h00005, 1'b0, 1'b0, "rd5");
    bus_read(18'h00005, 1'b1, 1'b0, "rd5_lb");
    bus_read(18'h00005, 1'b0, 1'b1, "rd5_ub");
  endtask

  task automatic test_lanes;
    bus_write(18'h3, 16'hFFFF, 1'b0, 1'b0);
    bus_write(18'h3, 16'h1122, 1'b1, 1'b0);
    checks++;
    if (model[3] !== 16'hFF22) begin
      failures++;
      $display("FAIL lane_model: model=%h required ff22", model[3]);
    end
    bus_read(18'h3, 1'b0, 1'b0, "rd3");
    bus_write(18'h3, 16'hAB00, 1'b0, 1'b1);
    bus_write(18'h4, 16'h9999, 1'b0, 1'b0);
    bus_write(18'h4, 16'h0000, 1'b1, 1'b1);
    bus_read(18'h3, 1'b0, 1'b0, "rd3_ub");
    bus_read(18'h4, 1'b0, 1'b0, "rd4_nolane");
  endtask

  task automatic test_alias;
    bus_write(18'h00041, 16'hBEEF, 1'b0, 1'b0);
    bus_read(18'h00001, 1'b0, 1'b0, "alias");
    bus_write(18'h3FFC2, 16'h4242, 1'b0, 1'b0);
    bus_read(18'h00002, 1'b0, 1'b0, "alias_hi");
  endtask

  task automatic test_reset_mid_write;
    bus_write(18'h7, 16'h0F0F, 1'b0, 1'b0);
    a = 18'h7; dq_in = 16'h7777; ub_n = 1'b0; lb_n = 1'b0; cs_n = 1'b0;
    tick(1);
    we_n = 1'b0;
    tick(3);
    rst = 1'b1;
    #1;
    checks++;
    if (dq_oe !== 16'h0 || err !== 1'b0 || dq_out !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid_write: out=%h oe=%h err=%b required 0/0/0", dq_out, dq_oe, err);
    end
    tick(1);
    we_n = 1'b1; cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    bus_read(18'h7, 1'b0, 1'b0, "rd7_after_rst");
  endtask

  task automatic test_bypass;
    logic [15:0] e;
    bus_write(18'h9, 16'h5555, 1'b0, 1'b0);
    a = 18'h9; dq_in = 16'h1234; ub_n = 1'b0; lb_n = 1'b0; cs_n = 1'b0;
    tick(1);
    we_n = 1'b0;
    tick(3);
    we_n = 1'b1; oe_n = 1'b0;
    model_write(18'h9, 16'h1234, 1'b0, 1'b0);
    exp_q.push_back(model[9]);
    @(posedge clk); @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (dq_oe !== 16'hFFFF || dq_out !== e) begin
      failures++;
      $display("FAIL bypass: out=%h oe=%h required %h/ffff", dq_out, dq_oe, e);
    end
    oe_n = 1'b1; cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    tick(3);
    bus_read(18'h9, 1'b0, 1'b0, "rd9_after_bypass");
  endtask

  task automatic test_err;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_pre: err=%b required 0", err);
    end
    a = 18'd20; dq_in = 16'h3333; ub_n = 1'b0; lb_n = 1'b0;
    cs_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
    tick(1);
    we_n = 1'b1; oe_n = 1'b1; cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    model_write(18'd20, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (dq_oe !== 16'h0) begin
        failures++;
        $display("FAIL err_oe_%0d: oe=%h required 0000", i, dq_oe);
      end
    end
    checks++;
    if (err !== ERR_EN) begin
      failures++;
      $display("FAIL err_set: err=%b required %b", err, ERR_EN);
    end
    tick(5);
    checks++;
    if (err !== ERR_EN) begin
      failures++;
      $display("FAIL err_sticky: err=%b required %b", err, ERR_EN);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
    bus_read(18'd20, 1'b0, 1'b0, "rd20");
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_lanes;
    test_alias;
    test_reset_mid_write;
    test_bypass;
    test_err;
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
